instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: whole lines are written into a circular word array and
// 0..MAX_RD words are consumed per cycle. Supports redirect flushes with an entry offset.
module instr_fetch_queue #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_RD     = 2,
  localparam int unsigned TOT       = DEPTH * LINE_WORDS,
  localparam int unsigned PW        = $clog2(TOT),
  localparam int unsigned CW        = $clog2(TOT + 1),
  localparam int unsigned OW        = $clog2(LINE_WORDS),
  localparam int unsigned RW        = $clog2(MAX_RD + 1)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [LINE_WORDS*WORD_WIDTH-1:0] i_line_data,
  input  logic                           i_line_valid,
  output logic                           o_line_ready,
  input  logic [RW-1:0]                  i_rd_cnt,
  output logic [MAX_RD*WORD_WIDTH-1:0]   o_rd_data,
  output logic [RW-1:0]                  o_rd_avail,
  input  logic                           i_flush,
  input  logic [OW-1:0]                  i_flush_offset,
  output logic [CW-1:0]                  o_count,
  output logic                           o_empty,
  output logic                           o_redirect_pend,
  output logic                           o_ovf_err,
  output logic                           o_udf_err
);

  typedef enum logic [0:0] {StRun, StWaitLine} state_e;

  state_e                 state_q, state_d;
  logic [WORD_WIDTH-1:0]  mem_q [TOT];
  logic [WORD_WIDTH-1:0]  mem_d [TOT];
  logic [PW-1:0]          wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]          count_q, count_d;
  logic [OW-1:0]          off_q, off_d;
  logic                   ovf_q, ovf_d, udf_q, udf_d;

  logic                   line_ready;
  logic [RW-1:0]          rd_avail, rd_eff;
  logic                   wr_en;
  logic [PW-1:0]          wr_base;
  logic [OW-1:0]          load_off;

  assign line_ready = (CW'(TOT) - count_q) >= CW'(LINE_WORDS);
  assign rd_avail   = (count_q > CW'(MAX_RD)) ? RW'(MAX_RD) : RW'(count_q);
  assign rd_eff     = (i_rd_cnt > rd_avail) ? rd_avail : i_rd_cnt;
  assign load_off   = i_flush ? i_flush_offset : off_q;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = i_line_valid ? StRun : StWaitLine;
    end else if (state_q == StWaitLine && i_line_valid) begin
      state_d = StRun;
    end
  end

  // Outputs
  always_comb begin
    o_redirect_pend = (state_q == StWaitLine);
    o_line_ready    = line_ready;
    o_rd_avail      = rd_avail;
    o_count         = count_q;
    o_empty         = (count_q == '0);
    o_ovf_err       = ovf_q;
    o_udf_err       = udf_q;
    o_rd_data       = '0;
    for (int k = 0; k < int'(MAX_RD); k++) begin
      o_rd_data[k*WORD_WIDTH +: WORD_WIDTH] = mem_q[rp_q + PW'(k)];
    end
  end

  // Datapath: a flush or the first write after a bare flush reloads the array from slot 0
  always_comb begin
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    off_d   = off_q;
    wr_en   = 1'b0;
    wr_base = '0;
    ovf_d   = ovf_q | (!i_flush && i_line_valid && !line_ready);
    udf_d   = udf_q | (!i_flush && (i_rd_cnt > rd_avail));

    if ((i_flush || state_q == StWaitLine) && i_line_valid) begin
      wr_en   = 1'b1;
      rp_d    = PW'(load_off);
      wp_d    = PW'(LINE_WORDS);
      count_d = CW'(LINE_WORDS) - CW'(load_off);
    end else if (i_flush) begin
      rp_d    = '0;
      wp_d    = '0;
      count_d = '0;
      off_d   = i_flush_offset;
    end else if (state_q == StRun) begin
      wr_en   = i_line_valid && line_ready;
      wr_base = wp_q;
      if (wr_en) begin
        wp_d = wp_q + PW'(LINE_WORDS);
      end
      rp_d    = rp_q + PW'(rd_eff);
      count_d = count_q + (wr_en ? CW'(LINE_WORDS) : CW'(0)) - CW'(rd_eff);
    end

    if (wr_en) begin
      for (int i = 0; i < int'(LINE_WORDS); i++) begin
        mem_d[wr_base + PW'(i)] = i_line_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      off_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      off_q   <= off_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios then random traffic, all checked
// against a word-queue reference model.
module tb_instr_fetch_queue;
  localparam int WW  = 32;
  localparam int LW  = 4;
  localparam int MR  = 2;
  localparam int TOT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [LW*WW-1:0] line_data;
  logic            line_valid;
  logic            line_ready;
  logic [1:0]      rd_cnt;
  logic [MR*WW-1:0] rd_data;
  logic [1:0]      rd_avail;
  logic            flush;
  logic [1:0]      flush_off;
  logic [4:0]      count;
  logic            empty, pend, ovf, udf;

  always #5 clk = ~clk;

  instr_fetch_queue dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_line_data    (line_data),
    .i_line_valid   (line_valid),
    .o_line_ready   (line_ready),
    .i_rd_cnt       (rd_cnt),
    .o_rd_data      (rd_data),
    .o_rd_avail     (rd_avail),
    .i_flush        (flush),
    .i_flush_offset (flush_off),
    .o_count        (count),
    .o_empty        (empty),
    .o_redirect_pend(pend),
    .o_ovf_err      (ovf),
    .o_udf_err      (udf)
  );

  // Reference model: the queue holds exactly the words a consumer may still read
  logic [WW-1:0] mq[$];
  bit  m_wait, m_ovf, m_udf;
  int  m_off;
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [LW*WW-1:0] mk(input int base);
    logic [LW*WW-1:0] d;
    for (int i = 0; i < LW; i++) d[i*WW +: WW] = WW'(base + i);
    return d;
  endfunction

  task automatic load(input logic [LW*WW-1:0] d, input int off);
    mq.delete();
    for (int i = off; i < LW; i++) mq.push_back(d[i*WW +: WW]);
  endtask

  task automatic check_outputs(input string tag);
    int av;
    av = imin(mq.size(), MR);
    chk({tag, ".count"}, 64'(count), 64'(mq.size()));
    chk({tag, ".empty"}, 64'(empty), 64'(mq.size() == 0));
    chk({tag, ".avail"}, 64'(rd_avail), 64'(av));
    chk({tag, ".ready"}, 64'(line_ready), 64'((TOT - mq.size()) >= LW));
    chk({tag, ".pend"}, 64'(pend), 64'(m_wait));
    chk({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));
    chk({tag, ".udf"}, 64'(udf), 64'(m_udf));
    for (int k = 0; k < av; k++) chk({tag, ".data"}, 64'(rd_data[k*WW +: WW]), 64'(mq[k]));
  endtask

  task automatic model_update(input bit r, input bit v, input logic [LW*WW-1:0] d,
                              input int rd, input bit f, input int off);
    int av, eff;
    bit rdy;
    if (r) begin
      mq.delete(); m_wait = 0; m_off = 0; m_ovf = 0; m_udf = 0;
    end else if (f) begin
      if (v) begin
        load(d, off); m_wait = 0;
      end else begin
        mq.delete(); m_wait = 1; m_off = off;
      end
    end else begin
      av  = imin(mq.size(), MR);
      eff = imin(rd, av);
      rdy = (TOT - mq.size()) >= LW;
      if (rd > av) m_udf = 1;
      if (m_wait) begin
        if (v) begin
          load(d, m_off); m_wait = 0;
        end
      end else begin
        repeat (eff) void'(mq.pop_front());
        if (v) begin
          if (rdy) for (int i = 0; i < LW; i++) mq.push_back(d[i*WW +: WW]);
          else m_ovf = 1;
        end
      end
    end
  endtask

  // Drive one cycle: check pre-edge outputs, clock, then advance the model
  task automatic step(input string tag, input bit r, input bit v, input logic [LW*WW-1:0] d,
                      input int rd, input bit f, input int off);
    rst = r; line_valid = v; line_data = d; rd_cnt = 2'(rd); flush = f; flush_off = 2'(off);
    #1;
    check_outputs(tag);
    @(posedge clk);
    model_update(r, v, d, rd, f, off);
    #1;
  endtask

  logic [LW*WW-1:0] abcd, efgh, rnd;
  bit  rr, rv, rf;
  int  rrd, roff;

  initial begin
    abcd = {32'hD, 32'hC, 32'hB, 32'hA};
    efgh = {32'h1000_0008, 32'h1000_0007, 32'h1000_0006, 32'h1000_0005};
    rst = 1'b1; line_valid = 0; line_data = '0; rd_cnt = 0; flush = 0; flush_off = 0;
    @(posedge clk);
    model_update(1, 0, '0, 0, 0, 0);
    #1;

    // Fill to capacity, then overflow
    for (int i = 0; i < 4; i++) step("fill", 0, 1, mk(4 * i), 0, 0, 0);
    step("ovf", 0, 1, mk(100), 0, 0, 0);
    // Drain two words per cycle
    for (int i = 0; i < 8; i++) step("drain", 0, 0, '0, 2, 0, 0);
    step("drained", 0, 0, '0, 0, 0, 0);

    // Simultaneous write/read across the array wrap
    step("rst1", 1, 0, '0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step("wrrd", 0, 1, mk(32 + 4 * i), 1 + (i % 2), 0, 0);
    for (int i = 0; i < 10; i++) step("wrap", 0, (i % 3) == 0, mk(80 + 4 * i), 2, 0, 0);

    // Flush with a line at offset 3 from count 6
    step("rst2", 1, 0, '0, 0, 0, 0);
    step("w0", 0, 1, mk(0), 0, 0, 0);
    step("w1", 0, 1, mk(4), 0, 0, 0);
    step("r6", 0, 0, '0, 2, 0, 0);
    step("flw", 0, 1, abcd, 0, 1, 3);
    step("flw_chk", 0, 0, '0, 0, 0, 0);

    // Bare flush, then the line arrives
    step("fl", 0, 0, '0, 0, 1, 2);
    step("wait_rd", 0, 0, '0, 1, 0, 0);
    step("rst3", 1, 0, '0, 0, 0, 0);
    step("fl2", 0, 0, '0, 0, 1, 2);
    step("wait_w", 0, 1, efgh, 0, 0, 0);
    step("after_w", 0, 0, '0, 0, 0, 0);

    // Underflow from count 1, then reset clears everything
    step("fl3", 0, 1, abcd, 0, 1, 3);
    step("udf", 0, 0, '0, 2, 0, 0);
    step("post_udf", 0, 0, '0, 0, 0, 0);
    step("rst4", 1, 1, mk(200), 2, 1, 1);
    step("post_rst", 0, 0, '0, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rr   = ($urandom_range(0, 59) == 0);
      rf   = ($urandom_range(0, 15) == 0);
      rv   = $urandom_range(0, 1) == 1;
      rrd  = rf ? 0 : $urandom_range(0, 3);
      roff = $urandom_range(0, LW - 1);
      rnd  = {$urandom, $urandom, $urandom, $urandom};
      step("rand", rr, rv, rnd, rrd, rf, roff);
    end
    step("final", 0, 0, '0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
